// File: rtl/multi_zone_irrigation_fsm.sv
// ---------------------------------------------------------------------------
// multi_zone_irrigation_fsm
//
// Tank and valve controller for ZONES irrigation zones that share one tank.
// Zone watering requests are served round-robin, and each grant is held for
// at least MIN_WATER ticks and at most MAX_WATER ticks. Refilling the tank
// takes priority over watering. A refill that does not reach tank_full within
// MAX_FILL ticks latches a fault. The same fault is latched when both level
// sensors report at once. The fault stays until fault_clear is pulsed.
//
// Ports
//   clock          in   1      system clock, rising edge
//   reset          in   1      asynchronous, active-high
//   tick_i         in   1      one-cycle timebase strobe; only timers use it
//   zone_req_i     in   ZONES  bit i set = zone i is dry and requests water
//   tank_low_i     in   1      tank is below the watering threshold
//   tank_full_i    in   1      tank is at full level
//   fault_clear_i  in   1      one-cycle pulse that leaves FAULT
//   valve_o        out  ZONES  valve drive, one-hot or zero
//   filling_o      out  1      fill pump drive
//   active_zone_o  out  ZW     index of the granted zone, 0 unless watering
//   fault_o        out  1      latched fill-timeout or sensor-conflict fault
// ---------------------------------------------------------------------------
module multi_zone_irrigation_fsm #(
   parameter int ZONES     = 4,
   parameter int TIMER_W   = 16,
   parameter int MIN_WATER = 10,
   parameter int MAX_WATER = 600,
   parameter int MAX_FILL  = 1200,
   localparam int ZW       = (ZONES > 1) ? $clog2(ZONES) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick_i,
   input  logic [ZONES-1:0] zone_req_i,
   input  logic             tank_low_i,
   input  logic             tank_full_i,
   input  logic             fault_clear_i,
   output logic [ZONES-1:0] valve_o,
   output logic             filling_o,
   output logic [ZW-1:0]    active_zone_o,
   output logic             fault_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WATERING = 2'd1,
      ST_FILLING  = 2'd2,
      ST_FAULT    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [ZW-1:0]      zone_q, zone_d;
   logic [ZW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [ZONES-1:0]   valve_q, valve_d;
   logic               filling_q, filling_d;
   logic [ZW-1:0]      active_zone_q, active_zone_d;
   logic               fault_q, fault_d;

   logic               any_req_s;
   logic               end_grant_s;
   logic               regrant_s;
   logic               restart_s;
   logic [ZW-1:0]      next_ptr_s;

   // This is the first requesting zone at or above ptr. The search wraps past
   // ZONES-1 to zone 0.
   function automatic logic [ZW-1:0] rr_pick(input logic [ZONES-1:0] req,
                                             input logic [ZW-1:0]    ptr);
      logic [ZW-1:0] pick;
      logic          found;
      int            idx;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < ZONES; k++) begin
         idx = (int'(ptr) + k) % ZONES;
         if (!found && req[idx]) begin
            pick  = ZW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // This is (z + 1) mod ZONES. ZONES does not need to be a power of two.
   function automatic logic [ZW-1:0] zone_inc(input logic [ZW-1:0] z);
      if (z == ZW'(ZONES - 1)) begin
         return {ZW{1'b0}};
      end else begin
         return z + ZW'(1);
      end
   endfunction

   assign any_req_s   = |zone_req_i;
   assign next_ptr_s  = zone_inc(zone_q);
   // A grant ends when the zone has finished after its minimum time, or when
   // the maximum time has run out even though the zone still requests water.
   assign end_grant_s = (!zone_req_i[zone_q] && (timer_q >= TIMER_W'(MIN_WATER))) ||
                        (timer_q >= TIMER_W'(MAX_WATER));

   // This computes the next state and the next zone, and advances the
   // round-robin pointer.
   always_comb begin
      state_d   = state_q;
      zone_d    = zone_q;
      rr_ptr_d  = rr_ptr_q;
      regrant_s = 1'b0;
      if ((state_q != ST_FAULT) && tank_low_i && tank_full_i) begin
         // Both level sensors are active at once. The tank level cannot be
         // trusted, so the controller goes to FAULT.
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (tank_low_i) begin
                  state_d = ST_FILLING;
               end else if (any_req_s) begin
                  state_d  = ST_WATERING;
                  zone_d   = rr_pick(zone_req_i, rr_ptr_q);
                  // The pointer follows the zone that holds the grant. A
                  // zone preempted by a refill is therefore searched first
                  // when watering resumes.
                  rr_ptr_d = zone_d;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_WATERING: begin
               if (tank_low_i) begin
                  state_d = ST_FILLING;
               end else if (end_grant_s) begin
                  rr_ptr_d = next_ptr_s;
                  if (any_req_s) begin
                     // The search starts just above the zone that is
                     // yielding. That zone is reached last, so it is only
                     // served again when it is the sole requester.
                     zone_d    = rr_pick(zone_req_i, next_ptr_s);
                     rr_ptr_d  = zone_d;
                     regrant_s = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  state_d = ST_WATERING;
               end
            end
            ST_FILLING: begin
               if (tank_full_i) begin
                  state_d = ST_IDLE;
               end else if (timer_q >= TIMER_W'(MAX_FILL)) begin
                  state_d = ST_FAULT;
               end else begin
                  state_d = ST_FILLING;
               end
            end
            ST_FAULT: begin
               if (fault_clear_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_FAULT;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // The timer restarts on every new grant, state change or zone change. It
   // counts ticks and saturates at all-ones.
   always_comb begin
      restart_s = (state_d != state_q) || (zone_d != zone_q) || regrant_s;
      if (restart_s) begin
         timer_d = {TIMER_W{1'b0}};
      end else if (tick_i && (timer_q != {TIMER_W{1'b1}})) begin
         timer_d = timer_q + TIMER_W'(1);
      end else begin
         timer_d = timer_q;
      end
   end

   // The output drives are decoded from the next state so that they change
   // on the same edge as the state register.
   always_comb begin
      valve_d       = {ZONES{1'b0}};
      active_zone_d = {ZW{1'b0}};
      filling_d     = 1'b0;
      fault_d       = 1'b0;
      case (state_d)
         ST_WATERING: begin
            valve_d       = ZONES'(1) << zone_d;
            active_zone_d = zone_d;
         end
         ST_FILLING: begin
            filling_d = 1'b1;
         end
         ST_FAULT: begin
            fault_d = 1'b1;
         end
         default: begin
            valve_d = {ZONES{1'b0}};
         end
      endcase
   end

   // This is the state, timer and pointer register. Reset is asynchronous.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         zone_q   <= {ZW{1'b0}};
         rr_ptr_q <= {ZW{1'b0}};
         timer_q  <= {TIMER_W{1'b0}};
      end else begin
         state_q  <= state_d;
         zone_q   <= zone_d;
         rr_ptr_q <= rr_ptr_d;
         timer_q  <= timer_d;
      end
   end

   // This registers the drives. Reset turns off every drive at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valve_q       <= {ZONES{1'b0}};
         filling_q     <= 1'b0;
         active_zone_q <= {ZW{1'b0}};
         fault_q       <= 1'b0;
      end else begin
         valve_q       <= valve_d;
         filling_q     <= filling_d;
         active_zone_q <= active_zone_d;
         fault_q       <= fault_d;
      end
   end

   assign valve_o       = valve_q;
   assign filling_o     = filling_q;
   assign active_zone_o = active_zone_q;
   assign fault_o       = fault_q;

endmodule

// File: tb/tb_multi_zone_irrigation_fsm.sv
// ---------------------------------------------------------------------------
// tb_multi_zone_irrigation_fsm
//
// Directed testbench for multi_zone_irrigation_fsm with the default
// parameters: ZONES=4, MIN_WATER=10, MAX_WATER=600 and MAX_FILL=1200.
// Inputs are driven and outputs are sampled on the falling clock edge.
// Outputs are compared as one packed vector {valve, filling, active_zone,
// fault}.
// ---------------------------------------------------------------------------
module tb_multi_zone_irrigation_fsm;

   logic       clock;
   logic       reset;
   logic       tick;
   logic [3:0] zone_req;
   logic       tank_low;
   logic       tank_full;
   logic       fault_clear;
   logic [3:0] valve;
   logic       filling;
   logic [1:0] active_zone;
   logic       fault;
   logic [7:0] outs;

   int n_cmp;
   int n_mis;

   multi_zone_irrigation_fsm #(
      .ZONES    (4),
      .TIMER_W  (16),
      .MIN_WATER(10),
      .MAX_WATER(600),
      .MAX_FILL (1200)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .tick_i       (tick),
      .zone_req_i   (zone_req),
      .tank_low_i   (tank_low),
      .tank_full_i  (tank_full),
      .fault_clear_i(fault_clear),
      .valve_o      (valve),
      .filling_o    (filling),
      .active_zone_o(active_zone),
      .fault_o      (fault)
   );

   assign outs = {valve, filling, active_zone, fault};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Holds reset for two cycles with every input idle, then releases it.
   task automatic apply_reset();
      reset       = 1'b1;
      tick        = 1'b0;
      zone_req    = 4'b0000;
      tank_low    = 1'b0;
      tank_full   = 1'b0;
      fault_clear = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // Issues n tick strobes. Each strobe is one cycle high, then one cycle low.
   task automatic do_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(negedge clock);
         tick = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (outs !== 8'b0000_0_00_0) begin
         n_mis++;
         $display("FAIL reset_held: got %b want %b", outs, 8'b0000_0_00_0);
      end
      apply_reset();
      n_cmp++;
      if (outs !== 8'b0000_0_00_0) begin
         n_mis++;
         $display("FAIL reset_released: got %b want %b", outs, 8'b0000_0_00_0);
      end
   endtask

   task automatic test_min_water_switch();
      apply_reset();
      zone_req = 4'b0101;
      @(negedge clock);
      n_cmp++;
      if (outs !== {4'b0001, 1'b0, 2'd0, 1'b0}) begin
         n_mis++;
         $display("FAIL grant_zone0: got %b want %b", outs, {4'b0001, 1'b0, 2'd0, 1'b0});
      end
      zone_req = 4'b0100;
      do_ticks(9);
      n_cmp++;
      if (outs !== {4'b0001, 1'b0, 2'd0, 1'b0}) begin
         n_mis++;
         $display("FAIL min_water_hold: got %b want %b", outs, {4'b0001, 1'b0, 2'd0, 1'b0});
      end
      do_ticks(1);
      n_cmp++;
      if (outs !== {4'b0100, 1'b0, 2'd2, 1'b0}) begin
         n_mis++;
         $display("FAIL switch_zone2: got %b want %b", outs, {4'b0100, 1'b0, 2'd2, 1'b0});
      end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_v;
      logic [1:0] exp_z;
      apply_reset();
      zone_req = 4'b1111;
      @(negedge clock);
      n_cmp++;
      if (outs !== {4'b0001, 1'b0, 2'd0, 1'b0}) begin
         n_mis++;
         $display("FAIL rot_start: got %b want %b", outs, {4'b0001, 1'b0, 2'd0, 1'b0});
      end
      for (int g = 1; g <= 4; g++) begin
         exp_z = 2'((g - 1) % 4);
         exp_v = 4'b0001 << exp_z;
         do_ticks(599);
         n_cmp++;
         if (outs !== {exp_v, 1'b0, exp_z, 1'b0}) begin
            n_mis++;
            $display("FAIL rot_hold_%0d: got %b want %b", g, outs, {exp_v, 1'b0, exp_z, 1'b0});
         end
         exp_z = 2'(g % 4);
         exp_v = 4'b0001 << exp_z;
         do_ticks(1);
         n_cmp++;
         if (outs !== {exp_v, 1'b0, exp_z, 1'b0}) begin
            n_mis++;
            $display("FAIL rot_next_%0d: got %b want %b", g, outs, {exp_v, 1'b0, exp_z, 1'b0});
         end
      end
   endtask

   task automatic test_sole_regrant();
      apply_reset();
      zone_req = 4'b0010;
      @(negedge clock);
      do_ticks(600);
      n_cmp++;
      if (outs !== {4'b0010, 1'b0, 2'd1, 1'b0}) begin
         n_mis++;
         $display("FAIL sole_regrant: got %b want %b", outs, {4'b0010, 1'b0, 2'd1, 1'b0});
      end
      // The new grant restarts the timer, so MIN_WATER applies again.
      zone_req = 4'b0000;
      do_ticks(9);
      n_cmp++;
      if (outs !== {4'b0010, 1'b0, 2'd1, 1'b0}) begin
         n_mis++;
         $display("FAIL regrant_min_hold: got %b want %b", outs, {4'b0010, 1'b0, 2'd1, 1'b0});
      end
      do_ticks(1);
      n_cmp++;
      if (outs !== 8'b0000_0_00_0) begin
         n_mis++;
         $display("FAIL regrant_to_idle: got %b want %b", outs, 8'b0000_0_00_0);
      end
   endtask

   task automatic test_preempt();
      apply_reset();
      zone_req = 4'b0011;
      @(negedge clock);
      zone_req = 4'b0010;
      do_ticks(10);
      n_cmp++;
      if (outs !== {4'b0010, 1'b0, 2'd1, 1'b0}) begin
         n_mis++;
         $display("FAIL pre_zone1: got %b want %b", outs, {4'b0010, 1'b0, 2'd1, 1'b0});
      end
      do_ticks(3);
      tank_low = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (outs !== {4'b0000, 1'b1, 2'd0, 1'b0}) begin
         n_mis++;
         $display("FAIL preempt_fill: got %b want %b", outs, {4'b0000, 1'b1, 2'd0, 1'b0});
      end
      tank_low = 1'b0;
      zone_req = 4'b0011;
      @(negedge clock);
      n_cmp++;
      if (outs !== {4'b0000, 1'b1, 2'd0, 1'b0}) begin
         n_mis++;
         $display("FAIL fill_ignores_req: got %b want %b", outs, {4'b0000, 1'b1, 2'd0, 1'b0});
      end
      tank_full = 1'b1;
      @(negedge clock);
      tank_full = 1'b0;
      n_cmp++;
      if (outs !== 8'b0000_0_00_0) begin
         n_mis++;
         $display("FAIL full_to_idle: got %b want %b", outs, 8'b0000_0_00_0);
      end
      @(negedge clock);
      n_cmp++;
      if (outs !== {4'b0010, 1'b0, 2'd1, 1'b0}) begin
         n_mis++;
         $display("FAIL regrant_zone1: got %b want %b", outs, {4'b0010, 1'b0, 2'd1, 1'b0});
      end
   endtask

   task automatic test_fill_timeout();
      apply_reset();
      tank_low = 1'b1;
      @(negedge clock);
      tank_low = 1'b0;
      do_ticks(1199);
      n_cmp++;
      if (outs !== {4'b0000, 1'b1, 2'd0, 1'b0}) begin
         n_mis++;
         $display("FAIL fill_before_to: got %b want %b", outs, {4'b0000, 1'b1, 2'd0, 1'b0});
      end
      do_ticks(1);
      n_cmp++;
      if (outs !== {4'b0000, 1'b0, 2'd0, 1'b1}) begin
         n_mis++;
         $display("FAIL fill_timeout: got %b want %b", outs, {4'b0000, 1'b0, 2'd0, 1'b1});
      end
      zone_req = 4'b1111;
      @(negedge clock);
      @(negedge clock);
      n_cmp++;
      if (outs !== {4'b0000, 1'b0, 2'd0, 1'b1}) begin
         n_mis++;
         $display("FAIL fault_latched: got %b want %b", outs, {4'b0000, 1'b0, 2'd0, 1'b1});
      end
      zone_req    = 4'b0000;
      fault_clear = 1'b1;
      @(negedge clock);
      fault_clear = 1'b0;
      n_cmp++;
      if (outs !== 8'b0000_0_00_0) begin
         n_mis++;
         $display("FAIL fault_clear: got %b want %b", outs, 8'b0000_0_00_0);
      end
      // tank_full arrives on the timeout cycle and wins over the timeout.
      tank_low = 1'b1;
      @(negedge clock);
      tank_low = 1'b0;
      do_ticks(1199);
      tick = 1'b1;
      @(negedge clock);
      tick      = 1'b0;
      tank_full = 1'b1;
      @(negedge clock);
      tank_full = 1'b0;
      n_cmp++;
      if (outs !== 8'b0000_0_00_0) begin
         n_mis++;
         $display("FAIL full_beats_timeout: got %b want %b", outs, 8'b0000_0_00_0);
      end
   endtask

   task automatic test_low_beats_req();
      apply_reset();
      tank_low = 1'b1;
      zone_req = 4'b0010;
      @(negedge clock);
      n_cmp++;
      if (outs !== {4'b0000, 1'b1, 2'd0, 1'b0}) begin
         n_mis++;
         $display("FAIL low_beats_req: got %b want %b", outs, {4'b0000, 1'b1, 2'd0, 1'b0});
      end
   endtask

   task automatic test_sensor_conflict();
      apply_reset();
      zone_req = 4'b0001;
      @(negedge clock);
      tank_low  = 1'b1;
      tank_full = 1'b1;
      @(negedge clock);
      n_cmp++;
      if (outs !== {4'b0000, 1'b0, 2'd0, 1'b1}) begin
         n_mis++;
         $display("FAIL sensor_conflict: got %b want %b", outs, {4'b0000, 1'b0, 2'd0, 1'b1});
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      zone_req = 4'b0100;
      @(negedge clock);
      n_cmp++;
      if (outs !== {4'b0100, 1'b0, 2'd2, 1'b0}) begin
         n_mis++;
         $display("FAIL pre_async_zone2: got %b want %b", outs, {4'b0100, 1'b0, 2'd2, 1'b0});
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (outs !== 8'b0000_0_00_0) begin
         n_mis++;
         $display("FAIL async_reset: got %b want %b", outs, 8'b0000_0_00_0);
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_mis       = 0;
      reset       = 1'b1;
      tick        = 1'b0;
      zone_req    = 4'b0000;
      tank_low    = 1'b0;
      tank_full   = 1'b0;
      fault_clear = 1'b0;
      test_reset();
      test_min_water_switch();
      test_rotation();
      test_sole_regrant();
      test_preempt();
      test_fill_timeout();
      test_low_beats_req();
      test_sensor_conflict();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
